// File: rtl/lfsr_pkg.sv
// Shared types and defaults for the LFSR sequencer and its datapath.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         DEFAULT_WIDTH = 7;
    localparam logic [6:0] DEFAULT_TAPS  = 7'b1100000;
    localparam logic [6:0] DEFAULT_SEED  = 7'h7F;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register: shifts toward the MSB with the tap parity entering bit 0.
module lfsr_core #(
    parameter int               WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS  = 7'b1100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    logic fb;

    assign fb = ^(state & TAPS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= '1;
        end else if (load) begin
            state <= load_val;
        end else if (step) begin
            state <= {state[WIDTH-2:0], fb};
        end
    end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer owning an LFSR: runs a fixed number of shifts or measures the period back to the seed.
// Handshake: start is taken only in IDLE; busy is high while running; done pulses once on completion.
module lfsr_seq_ctrl
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS  = DEFAULT_TAPS,
    parameter int               CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] steps,
    output logic [WIDTH-1:0] saida,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period,
    output logic             overflow
);

    state_t           state;
    logic [WIDTH-1:0] seed_q;
    logic [CNT_W-1:0] steps_q;
    logic [CNT_W-1:0] counter;
    logic             mode_q;

    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             step;
    logic             m1_hit;
    logic             m1_sat;

    // Period end is seen one cycle after the returning shift, so done lands in cycle P+2.
    always_comb begin
        load     = (state == IDLE) && start;
        load_val = (seed == '0) ? '1 : seed;
        m1_hit   = (counter != '0) && (saida == seed_q);
        m1_sat   = (counter == '1);
        step     = 1'b0;
        if ((state == RUN) && !abort) begin
            step = mode_q ? !(m1_hit || m1_sat) : (counter != steps_q);
        end
    end

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .step     (step),
        .state    (saida)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            seed_q   <= '1;
            steps_q  <= '0;
            counter  <= '0;
            mode_q   <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            period   <= '0;
            overflow <= 1'b0;
        end else begin
            valid <= step;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        seed_q   <= load_val;
                        steps_q  <= steps;
                        mode_q   <= mode;
                        counter  <= '0;
                        period   <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (step) begin
                        counter <= counter + 1'b1;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                        if (!mode_q || m1_hit) begin
                            period <= counter;
                        end else begin
                            period   <= '1;
                            overflow <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
